// File: rtl/deserializador_fifo_if.sv
// Serial-in / word-out bus between the bit-stream producer and the word consumer.
interface deserializador_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             data_in;
    logic             write_in;
    logic             status_out;
    logic             flush_in;
    logic [WIDTH-1:0] data_out;
    logic             data_ready;
    logic             ack_in;
    logic [LW-1:0]    level_out;
    logic             drop_out;

    modport master (
        output data_in, write_in, flush_in, ack_in,
        input  status_out, data_out, data_ready, level_out, drop_out
    );

    modport slave (
        input  data_in, write_in, flush_in, ack_in,
        output status_out, data_out, data_ready, level_out, drop_out
    );
endinterface

// File: rtl/deserializador_fifo.sv
// Serial-to-parallel receiver feeding a first-word-fall-through word buffer.
// state    | meaning
// RX_IDLE  | no bits of the current word captured yet
// RX_SHIFT | 1..WIDTH-1 bits captured
// RX_STALL | buffer full, waiting for a pop
module deserializador_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clock_100KHz,
    input  logic                  reset,
    deserializador_fifo_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_STALL} rx_state_e;

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             drop_q, drop_d;

    logic             status;
    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] shifted;

    assign status = (level_q != LW'(DEPTH));

    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        drop_d    = 1'b0;
        push      = 1'b0;
        accept    = bus.write_in & status;
        pop       = bus.ack_in & (level_q != '0);
        // New bit enters at the end that ends up holding the last stream bit.
        shifted   = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.data_in}
                              : {bus.data_in, shift_q[WIDTH-1:1]};

        if (bus.flush_in) begin
            state_d   = RX_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end else begin
            drop_d = bus.write_in & ~status;

            if (accept) begin
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    push      = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shift_d   = shifted;
                end
            end

            if (push) begin
                mem_d[wr_ptr_q] = shifted;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end

            case (state_q)
                RX_STALL: begin
                    if (pop) state_d = RX_IDLE;
                end
                default: begin
                    if (push) begin
                        state_d = (level_d == LW'(DEPTH)) ? RX_STALL : RX_IDLE;
                    end else if (accept) begin
                        state_d = RX_SHIFT;
                    end
                end
            endcase
        end
    end

    assign bus.status_out = status;
    assign bus.data_ready = (level_q != '0);
    assign bus.data_out   = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.level_out  = level_q;
    assign bus.drop_out   = drop_q;
endmodule

// File: tb/tb_deserializador_fifo.sv
// Directed bench for deserializador_fifo: three configurations, scoreboard of expected words.
module tb_deserializador_fifo;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        din [3];
    logic        wr  [3];
    logic        fl  [3];
    logic        ack [3];
    logic [31:0] dout[3];
    logic [31:0] lvl [3];
    logic        rdy [3];
    logic        st  [3];
    logic        drp [3];

    logic [31:0] exp_q [3][$];
    int checks = 0;
    int errors = 0;

    deserializador_fifo_if #(.WIDTH(8),  .DEPTH(4)) b0();
    deserializador_fifo_if #(.WIDTH(8),  .DEPTH(4)) b1();
    deserializador_fifo_if #(.WIDTH(12), .DEPTH(2)) b2();

    deserializador_fifo #(.WIDTH(8),  .DEPTH(4), .MSB_FIRST(1'b0)) u0 (.clock_100KHz(clk), .reset(reset), .bus(b0));
    deserializador_fifo #(.WIDTH(8),  .DEPTH(4), .MSB_FIRST(1'b1)) u1 (.clock_100KHz(clk), .reset(reset), .bus(b1));
    deserializador_fifo #(.WIDTH(12), .DEPTH(2), .MSB_FIRST(1'b0)) u2 (.clock_100KHz(clk), .reset(reset), .bus(b2));

    assign b0.data_in = din[0]; assign b0.write_in = wr[0]; assign b0.flush_in = fl[0]; assign b0.ack_in = ack[0];
    assign b1.data_in = din[1]; assign b1.write_in = wr[1]; assign b1.flush_in = fl[1]; assign b1.ack_in = ack[1];
    assign b2.data_in = din[2]; assign b2.write_in = wr[2]; assign b2.flush_in = fl[2]; assign b2.ack_in = ack[2];

    assign dout[0] = 32'(b0.data_out); assign lvl[0] = 32'(b0.level_out);
    assign dout[1] = 32'(b1.data_out); assign lvl[1] = 32'(b1.level_out);
    assign dout[2] = 32'(b2.data_out); assign lvl[2] = 32'(b2.level_out);
    assign rdy[0] = b0.data_ready; assign st[0] = b0.status_out; assign drp[0] = b0.drop_out;
    assign rdy[1] = b1.data_ready; assign st[1] = b1.status_out; assign drp[1] = b1.drop_out;
    assign rdy[2] = b2.data_ready; assign st[2] = b2.status_out; assign drp[2] = b2.drop_out;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input int i, input logic b, input int gap);
        din[i] = b;
        wr[i]  = 1'b1;
        step();
        wr[i]  = 1'b0;
        din[i] = 1'b0;
        repeat (gap) step();
    endtask

    // Streams one word; the word is queued as expected output when it is driven.
    task automatic send_word(input int i, input logic [31:0] w, input int width,
                             input bit msb, input int gap, input string tag);
        logic [31:0] wv;
        wv = w;
        for (int k = 0; k < width; k++) begin
            send_bit(i, msb ? wv[width-1-k] : wv[k], gap);
            if (k == width - 2) chk({tag, "_lvl_before_last"}, lvl[i], 32'(exp_q[i].size()));
        end
        exp_q[i].push_back(wv);
        chk({tag, "_lvl"}, lvl[i], 32'(exp_q[i].size()));
        chk({tag, "_head"}, dout[i], exp_q[i][0]);
        chk({tag, "_rdy"}, 32'(rdy[i]), 32'd1);
    endtask

    task automatic pop_check(input int i, input string tag);
        logic [31:0] expw;
        if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=%0h expected=none", tag, dout[i]);
            return;
        end
        expw = exp_q[i].pop_front();
        chk({tag, "_rdy"}, 32'(rdy[i]), 32'd1);
        chk({tag, "_data"}, dout[i], expw);
        ack[i] = 1'b1;
        step();
        ack[i] = 1'b0;
        chk({tag, "_lvl_after"}, lvl[i], 32'(exp_q[i].size()));
        if (exp_q[i].size() == 0) begin
            chk({tag, "_empty_data"}, dout[i], 32'd0);
            chk({tag, "_empty_rdy"}, 32'(rdy[i]), 32'd0);
        end else begin
            chk({tag, "_next_head"}, dout[i], exp_q[i][0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i] = 1'b0; wr[i] = 1'b0; fl[i] = 1'b0; ack[i] = 1'b0;
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        chk("rst_status", 32'(st[0]), 32'd1);
        chk("rst_rdy", 32'(rdy[0]), 32'd0);
        chk("rst_data", dout[0], 32'd0);
        chk("rst_level", lvl[0], 32'd0);
        chk("rst_drop", 32'(drp[0]), 32'd0);

        // LSB-first word, back-to-back bits
        send_word(0, 32'h4D, 8, 1'b0, 0, "s1");
        pop_check(0, "s1_pop");

        // MSB-first word, back-to-back then with 3-cycle gaps
        send_word(1, 32'hB2, 8, 1'b1, 0, "s2a");
        pop_check(1, "s2a_pop");
        send_word(1, 32'hB2, 8, 1'b1, 3, "s2b");
        pop_check(1, "s2b_pop");

        // Fill buffer, overflow drops, then drain in order
        for (int w = 1; w <= 4; w++) send_word(0, 32'(w), 8, 1'b0, 0, "s3_fill");
        chk("s3_full_level", lvl[0], 32'd4);
        chk("s3_full_status", 32'(st[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            send_bit(0, 1'b1, 0);
            chk("s3_drop_pulse", 32'(drp[0]), 32'd1);
            chk("s3_drop_level", lvl[0], 32'd4);
        end
        step();
        chk("s3_drop_clear", 32'(drp[0]), 32'd0);
        pop_check(0, "s3_pop1");
        chk("s3_status_after_pop", 32'(st[0]), 32'd1);
        pop_check(0, "s3_pop2");
        pop_check(0, "s3_pop3");
        pop_check(0, "s3_pop4");

        // Ack on an empty buffer changes nothing
        ack[0] = 1'b1;
        step();
        ack[0] = 1'b0;
        chk("s6_empty_ack_level", lvl[0], 32'd0);
        chk("s6_empty_ack_rdy", 32'(rdy[0]), 32'd0);
        chk("s6_empty_ack_data", dout[0], 32'd0);

        // Last bit of a word and ack on the same edge
        send_word(0, 32'h11, 8, 1'b0, 0, "s4_a");
        send_word(0, 32'h22, 8, 1'b0, 0, "s4_b");
        for (int k = 0; k < 7; k++) send_bit(0, (k == 0 || k == 1 || k == 4 || k == 5), 0);
        void'(exp_q[0].pop_front());
        exp_q[0].push_back(32'h33);
        din[0] = 1'b0; wr[0] = 1'b1; ack[0] = 1'b1;
        step();
        din[0] = 1'b0; wr[0] = 1'b0; ack[0] = 1'b0;
        chk("s4_level", lvl[0], 32'd2);
        chk("s4_head", dout[0], 32'h22);
        pop_check(0, "s4_pop1");
        pop_check(0, "s4_pop2");

        // Flush mid-word with a queued word; write/ack in the flush cycle are ignored
        send_word(0, 32'h5A, 8, 1'b0, 0, "s5_pre");
        for (int k = 0; k < 3; k++) send_bit(0, 1'b0, 0);
        fl[0] = 1'b1; wr[0] = 1'b1; din[0] = 1'b0; ack[0] = 1'b1;
        step();
        fl[0] = 1'b0; wr[0] = 1'b0; ack[0] = 1'b0;
        exp_q[0].delete();
        chk("s5_flush_level", lvl[0], 32'd0);
        chk("s5_flush_rdy", 32'(rdy[0]), 32'd0);
        chk("s5_flush_data", dout[0], 32'd0);
        chk("s5_flush_drop", 32'(drp[0]), 32'd0);
        chk("s5_flush_status", 32'(st[0]), 32'd1);
        send_word(0, 32'hFF, 8, 1'b0, 0, "s5_ff");
        pop_check(0, "s5_ff_pop");

        // Same sequence with reset
        send_word(0, 32'h5A, 8, 1'b0, 0, "s5r_pre");
        for (int k = 0; k < 3; k++) send_bit(0, 1'b0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q[0].delete();
        chk("s5r_level", lvl[0], 32'd0);
        chk("s5r_rdy", 32'(rdy[0]), 32'd0);
        chk("s5r_data", dout[0], 32'd0);
        send_word(0, 32'hFF, 8, 1'b0, 0, "s5r_ff");
        pop_check(0, "s5r_ff_pop");

        // WIDTH=12, DEPTH=2 regression
        send_word(2, 32'h4D3, 12, 1'b0, 0, "s6w_a");
        pop_check(2, "s6w_a_pop");
        send_word(2, 32'h001, 12, 1'b0, 0, "s6w_f1");
        send_word(2, 32'hC02, 12, 1'b0, 1, "s6w_f2");
        chk("s6w_full_level", lvl[2], 32'd2);
        chk("s6w_full_status", 32'(st[2]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            send_bit(2, 1'b1, 0);
            chk("s6w_drop_pulse", 32'(drp[2]), 32'd1);
            chk("s6w_drop_level", lvl[2], 32'd2);
        end
        pop_check(2, "s6w_pop1");
        pop_check(2, "s6w_pop2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
